// File: rtl/regfile_preload.sv
// rtl/regfile_preload.sv - regfile write-port preloader with processor pass-through
//
// Loads registers FIRST_REG..NUM_REGS-1 from a valid/ready word stream before
// the processor runs, and holds the processor off while it does so. Outside a
// load, processor writes pass straight through to the regfile write port.
//
// Ports:
//   clock, reset            clock and synchronous active-high reset
//   start, abort            begin a load (IDLE only) / cancel a load (LOAD only)
//   in_valid, in_data       stream word for the current register index
//   in_ready                word accepted this cycle when in_valid (LOAD only)
//   proc_we/wreg/wdata      processor writeback request
//   rf_we/wreg/wdata        regfile write port
//   hold_cpu                keep the processor stalled
//   busy                    a load is in progress
//   done                    one-cycle pulse after a completed load
//   conflict                sticky: processor tried to write while held
module regfile_preload #(
  parameter int NUM_REGS   = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIRST_REG  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  proc_we,
  input  logic [4:0]            proc_wreg,
  input  logic [DATA_WIDTH-1:0] proc_wdata,
  output logic                  rf_we,
  output logic [4:0]            rf_wreg,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  hold_cpu,
  output logic                  busy,
  output logic                  done,
  output logic                  conflict
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(FIRST_REG);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    load_we_q, load_we_d;
  logic [4:0]              load_wreg_q, load_wreg_d;
  logic [DATA_WIDTH-1:0]   load_wdata_q, load_wdata_d;
  logic                    done_q, done_d;
  logic                    conflict_q, conflict_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= IDX_FIRST;
      load_we_q    <= 1'b0;
      load_wreg_q  <= 5'd0;
      load_wdata_q <= '0;
      done_q       <= 1'b0;
      conflict_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      load_we_q    <= load_we_d;
      load_wreg_q  <= load_wreg_d;
      load_wdata_q <= load_wdata_d;
      done_q       <= done_d;
      conflict_q   <= conflict_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    load_we_d    = load_we_q;
    load_wreg_d  = load_wreg_q;
    load_wdata_d = load_wdata_q;
    done_d       = 1'b0;
    conflict_d   = conflict_q;
    in_ready     = 1'b0;
    hold_cpu     = 1'b0;
    rf_we        = proc_we;
    rf_wreg      = proc_wreg;
    rf_wdata     = proc_wdata;

    case (state_q)
      ST_IDLE: begin
        // start beats a simultaneous abort simply because abort is not looked at here
        if (start) begin
          state_d    = ST_LOAD;
          idx_d      = IDX_FIRST;
          conflict_d = 1'b0;
        end
      end

      ST_LOAD: begin
        in_ready = 1'b1;
        hold_cpu = 1'b1;
        rf_we    = load_we_q;
        rf_wreg  = load_wreg_q;
        rf_wdata = load_wdata_q;
        if (proc_we) begin
          conflict_d = 1'b1;
        end
        if (abort) begin
          // the word offered alongside abort is dropped, not loaded
          state_d   = ST_IDLE;
          load_we_d = 1'b0;
          idx_d     = IDX_FIRST;
        end else if (in_valid) begin
          load_we_d    = 1'b1;
          load_wreg_d  = 5'(idx_q);
          load_wdata_d = in_data;
          // hold idx on the final beat rather than letting it wrap
          if (idx_q == IDX_LAST) begin
            state_d = ST_FLUSH;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          load_we_d = 1'b0;
        end
      end

      ST_FLUSH: begin
        // one extra held cycle so the last accepted word reaches the regfile
        hold_cpu  = 1'b1;
        rf_we     = load_we_q;
        rf_wreg   = load_wreg_q;
        rf_wdata  = load_wdata_q;
        if (proc_we) begin
          conflict_d = 1'b1;
        end
        load_we_d = 1'b0;
        done_d    = 1'b1;
        idx_d     = IDX_FIRST;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_regfile_preload.sv
// tb/tb_regfile_preload.sv - self-checking bench for regfile_preload
module tb_regfile_preload;
  localparam int NR = 32;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset, start, abort, in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          proc_we;
  logic [4:0]    proc_wreg;
  logic [DW-1:0] proc_wdata;
  logic          rf_we;
  logic [4:0]    rf_wreg;
  logic [DW-1:0] rf_wdata;
  logic          hold_cpu, busy, done, conflict;

  always #5 clock = ~clock;

  regfile_preload #(.NUM_REGS(NR), .DATA_WIDTH(DW), .FIRST_REG(1)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .proc_we(proc_we), .proc_wreg(proc_wreg), .proc_wdata(proc_wdata),
    .rf_we(rf_we), .rf_wreg(rf_wreg), .rf_wdata(rf_wdata),
    .hold_cpu(hold_cpu), .busy(busy), .done(done), .conflict(conflict)
  );

  // Environment regfile: r0 hardwired to zero, writes land on the clock edge.
  logic [DW-1:0] regs [NR] = '{default: '0};
  int cyc = 0;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (rf_we && rf_wreg != 5'd0) regs[rf_wreg] <= rf_wdata;
  end

  typedef struct {
    int            r;
    logic [DW-1:0] d;
    int            at;
  } wr_t;
  wr_t wlog[$];
  int  done_cnt = 0;
  int  done_bad = 0;
  always @(negedge clock) begin
    if (rf_we) wlog.push_back('{int'(rf_wreg), rf_wdata, cyc + 1});
    if (done) done_cnt <= done_cnt + 1;
    if (done && (busy || hold_cpu)) done_bad <= done_bad + 1;
  end

  // Expected register file, maintained from the stimulus alone.
  logic [DW-1:0] exp_rf [NR];

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One load session. pct<0 toggles in_valid 1/0; stop_kind 1=abort, 2=reset at stop_at beats.
  task automatic run_load(input int pct, input int stop_at, input int stop_kind,
                          input bit poke_conf, input bit poke_start, input bit with_abort);
    int            base_log, base_done, s_edge, beats, budget, n;
    bit            v, prev, stopped;
    logic [DW-1:0] q[$];
    base_log  = wlog.size();
    base_done = done_cnt;
    start = 1'b1;
    abort = with_abort;
    tick();
    start = 1'b0;
    abort = 1'b0;
    s_edge = cyc;
    check("start_busy", busy, 1);
    check("start_hold", hold_cpu, 1);
    check("start_conflict_clr", conflict, 0);
    beats = 0; prev = 0; stopped = 0; budget = 0;
    while (beats < NR - 1 && !stopped) begin
      if (budget > 400) begin
        check("load_budget", beats, NR - 1);
        break;
      end
      budget++;
      in_data = $urandom;
      if (stop_at != 0 && beats == stop_at) begin
        in_valid = 1'b1;
        if (stop_kind == 1) abort = 1'b1;
        else reset = 1'b1;
        #1;
        check("stop_rf_we", rf_we, prev);
        tick();
        abort = 1'b0; reset = 1'b0; in_valid = 1'b0;
        stopped = 1;
        check("stop_busy", busy, 0);
        check("stop_hold", hold_cpu, 0);
        check("stop_in_ready", in_ready, 0);
        check("stop_done", done, 0);
        check("stop_rf_passthru", rf_we, 0);
      end else begin
        v = (pct < 0) ? (budget % 2 == 1) : ($urandom_range(99, 0) < pct);
        in_valid = v;
        if (poke_conf && beats == 3) begin
          proc_we = 1'b1; proc_wreg = 5'd3; proc_wdata = 32'hDEAD_0003;
        end
        if (poke_start && beats == 7) start = 1'b1;
        #1;
        check("load_in_ready", in_ready, 1);
        check("load_rf_we", rf_we, prev);
        if (prev) begin
          check("load_rf_wreg", rf_wreg, beats);
          check("load_rf_wdata", rf_wdata, q[$]);
        end
        tick();
        proc_we = 1'b0; start = 1'b0; in_valid = 1'b0;
        if (v) begin
          q.push_back(in_data);
          exp_rf[beats + 1] = in_data;
          beats++;
        end
        prev = v;
      end
    end
    if (!stopped) begin
      check("flush_busy", busy, 1);
      check("flush_in_ready", in_ready, 0);
      check("flush_hold", hold_cpu, 1);
      check("flush_rf_we", rf_we, 1);
      check("flush_rf_wreg", rf_wreg, NR - 1);
      check("flush_rf_wdata", rf_wdata, q[$]);
      tick();
      check("done_pulse", done, 1);
      check("done_busy", busy, 0);
      check("done_hold", hold_cpu, 0);
      check("done_rf_we", rf_we, 0);
      tick();
      check("done_once", done, 0);
      check("conflict_sticky", conflict, poke_conf);
    end
    n = wlog.size() - base_log;
    check("write_count", n, beats);
    for (int i = 0; i < n && i < beats; i++) begin
      check("write_reg", wlog[base_log + i].r, i + 1);
      check("write_data", wlog[base_log + i].d, q[i]);
      if (pct == 100 && stop_kind == 0)
        check("write_cycle", wlog[base_log + i].at - s_edge, i + 2);
    end
    check("done_count", done_cnt - base_done, stopped ? 0 : 1);
  endtask

  typedef struct {
    logic          we;
    logic [4:0]    wreg;
    logic [DW-1:0] wdata;
    logic          e_we;
    logic [4:0]    e_wreg;
    logic [DW-1:0] e_wdata;
  } vec_t;
  vec_t tbl[5];

  initial begin
    for (int r = 0; r < NR; r++) exp_rf[r] = '0;
    tbl[0] = '{1'b1, 5'd3,  32'd7,         1'b1, 5'd3,  32'd7};
    tbl[1] = '{1'b0, 5'd5,  32'h1234_5678, 1'b0, 5'd5,  32'h1234_5678};
    tbl[2] = '{1'b1, 5'd0,  32'h0000_ABCD, 1'b1, 5'd0,  32'h0000_ABCD};
    tbl[3] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 5'd31, 32'hFFFF_FFFF};
    tbl[4] = '{1'b1, 5'd17, 32'h8000_0001, 1'b1, 5'd17, 32'h8000_0001};

    reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    proc_we = 1'b0; proc_wreg = '0; proc_wdata = '0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_hold", hold_cpu, 0);
    check("rst_done", done, 0);
    check("rst_conflict", conflict, 0);
    reset = 1'b0;
    tick();

    // IDLE pass-through vectors
    for (int i = 0; i < 5; i++) begin
      proc_we = tbl[i].we; proc_wreg = tbl[i].wreg; proc_wdata = tbl[i].wdata;
      #1;
      check("idle_rf_we", rf_we, tbl[i].e_we);
      check("idle_rf_wreg", rf_wreg, tbl[i].e_wreg);
      check("idle_rf_wdata", rf_wdata, tbl[i].e_wdata);
      check("idle_in_ready", in_ready, 0);
      tick();
      if (tbl[i].we && tbl[i].wreg != 0) exp_rf[tbl[i].wreg] = tbl[i].wdata;
    end
    proc_we = 1'b0;
    check("idle_r3_written", regs[3], 7);
    check("idle_r0_zero", regs[0], 0);

    // 1: back-to-back full load with latency check
    run_load(100, 0, 0, 0, 0, 0);
    // 2: in_valid toggling
    run_load(-1, 0, 0, 0, 0, 0);
    // 3: abort after 10 beats, then reload with start+abort together
    run_load(100, 10, 1, 0, 0, 0);
    run_load(70, 0, 0, 0, 0, 1);
    // 4: reset mid-load, then pass-through and a fresh load from r1
    run_load(100, 5, 2, 0, 0, 0);
    proc_we = 1'b1; proc_wreg = 5'd9; proc_wdata = 32'h0BAD_F00D;
    #1;
    check("post_rst_rf_we", rf_we, 1);
    check("post_rst_rf_wreg", rf_wreg, 9);
    proc_we = 1'b0;
    #1;
    check("post_rst_rf_we_off", rf_we, 0);
    run_load(60, 0, 0, 0, 0, 0);
    // 5: processor write during load flagged and dropped
    run_load(80, 0, 0, 1, 0, 0);
    check("conflict_r3_kept", regs[3], exp_rf[3]);
    proc_we = 1'b1; proc_wreg = 5'd3; proc_wdata = 32'd7;
    #1;
    check("idle_r3_rf_we", rf_we, 1);
    check("idle_r3_rf_wdata", rf_wdata, 7);
    tick();
    proc_we = 1'b0;
    exp_rf[3] = 32'd7;
    check("idle_r3_same_cycle", regs[3], 7);
    check("conflict_held_idle", conflict, 1);
    // 6: start during load ignored, processor run, read-back scan
    run_load(50, 0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      proc_we = 1'($urandom_range(1, 0));
      proc_wreg = 5'($urandom_range(31, 0));
      proc_wdata = $urandom;
      #1;
      check("run_rf_we", rf_we, proc_we);
      tick();
      if (proc_we && proc_wreg != 0) exp_rf[proc_wreg] = proc_wdata;
    end
    proc_we = 1'b0;
    tick();
    for (int r = 0; r < NR; r++) check("scan_reg", regs[r], exp_rf[r]);
    check("done_while_busy", done_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
